// File: rtl/icache_fill_unit_if.sv
// Shared bus types plus the fetch/memory-side bundle of the instruction cache.
// The cache takes the slave view; the fetch stage and memory controller side takes the master view.
package icache_pkg;
  localparam int XLEN = 32;
  typedef enum logic [1:0] {BUS_NONE = 2'd0, BUS_LOAD = 2'd1, BUS_STORE = 2'd2} bus_command_t;
  typedef enum logic {DCACHE = 1'b0, ICACHE = 1'b1} dest_cache_t;
endpackage

interface icache_fill_unit_if;
  import icache_pkg::*;

  logic              proc2Icache_req;
  logic [XLEN-1:0]   proc2Icache_addr;
  logic              icache_flush;
  logic [63:0]       Icache_data_out;
  logic              Icache_valid_out;
  bus_command_t      icache_command;
  logic [XLEN-1:0]   icache_addr;
  logic [3:0]        control2cache_response;
  dest_cache_t       control2cache_response_which;
  logic [63:0]       control2cache_data;
  logic [3:0]        control2cache_tag;
  dest_cache_t       control2cache_tag_which;
  logic [31:0]       icache_hit_count;
  logic [31:0]       icache_miss_count;

  modport slave (
    input  proc2Icache_req, proc2Icache_addr, icache_flush,
           control2cache_response, control2cache_response_which,
           control2cache_data, control2cache_tag, control2cache_tag_which,
    output Icache_data_out, Icache_valid_out, icache_command, icache_addr,
           icache_hit_count, icache_miss_count
  );

  modport master (
    output proc2Icache_req, proc2Icache_addr, icache_flush,
           control2cache_response, control2cache_response_which,
           control2cache_data, control2cache_tag, control2cache_tag_which,
    input  Icache_data_out, Icache_valid_out, icache_command, icache_addr,
           icache_hit_count, icache_miss_count
  );
endinterface

// File: rtl/icache_fill_unit.sv
// Direct-mapped read-only icache with a single-outstanding-miss fill engine.
// Hits answer combinationally; a miss requests until granted, then waits for its tagged return.
module icache_fill_unit
  import icache_pkg::*;
#(
  parameter int NUM_LINES = 32
) (
  input  logic              clock,
  input  logic              reset,
  icache_fill_unit_if.slave bus
);
  localparam int IDX  = $clog2(NUM_LINES);
  localparam int TAGW = XLEN - 3 - IDX;

  typedef enum logic {IDLE, WAIT_DATA} state_t;

  state_t                state_q, state_d;
  logic [NUM_LINES-1:0]  valid_q;
  logic [TAGW-1:0]       tag_q  [NUM_LINES];
  logic [63:0]           data_q [NUM_LINES];
  logic                  drop_q, drop_d;
  logic [3:0]            mem_tag_q, mem_tag_d;
  logic [IDX-1:0]        miss_idx_q, miss_idx_d;
  logic [TAGW-1:0]       miss_tag_q, miss_tag_d;
  logic [31:0]           hit_cnt_q, miss_cnt_q;

  logic [IDX-1:0]        req_idx;
  logic [TAGW-1:0]       req_tag;
  logic                  hit, miss_req, grant, ret_match, install;
  logic                  unused_offset;

  assign req_idx       = bus.proc2Icache_addr[3 +: IDX];
  assign req_tag       = bus.proc2Icache_addr[XLEN-1:3+IDX];
  assign unused_offset = ^bus.proc2Icache_addr[2:0];

  assign hit       = !reset && bus.proc2Icache_req && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign miss_req  = !reset && (state_q == IDLE) && bus.proc2Icache_req && !hit && !bus.icache_flush;
  assign grant     = miss_req && (bus.control2cache_response != 4'd0) &&
                     (bus.control2cache_response_which == ICACHE);
  assign ret_match = (state_q == WAIT_DATA) && (bus.control2cache_tag == mem_tag_q) &&
                     (bus.control2cache_tag_which == ICACHE);
  // A flush landing with the return beats the install: the line would be stale anyway.
  assign install   = ret_match && !drop_q && !bus.icache_flush;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (grant)     state_d = WAIT_DATA;
      WAIT_DATA: if (ret_match) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  always_comb begin
    drop_d     = drop_q;
    mem_tag_d  = mem_tag_q;
    miss_idx_d = miss_idx_q;
    miss_tag_d = miss_tag_q;
    if (grant) begin
      mem_tag_d  = bus.control2cache_response;
      miss_idx_d = req_idx;
      miss_tag_d = req_tag;
    end
    if (state_q == WAIT_DATA) begin
      if (ret_match)             drop_d = 1'b0;
      else if (bus.icache_flush) drop_d = 1'b1;
    end
  end

  always_comb begin
    bus.Icache_valid_out  = hit;
    bus.Icache_data_out   = hit ? data_q[req_idx] : 64'd0;
    bus.icache_command    = miss_req ? BUS_LOAD : BUS_NONE;
    bus.icache_addr       = miss_req ? {bus.proc2Icache_addr[XLEN-1:3], 3'b000} : '0;
    bus.icache_hit_count  = hit_cnt_q;
    bus.icache_miss_count = miss_cnt_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      drop_q     <= 1'b0;
      mem_tag_q  <= 4'd0;
      miss_idx_q <= '0;
      miss_tag_q <= '0;
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      drop_q     <= drop_d;
      mem_tag_q  <= mem_tag_d;
      miss_idx_q <= miss_idx_d;
      miss_tag_q <= miss_tag_d;
      if (hit)   hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (grant) miss_cnt_q <= miss_cnt_q + 32'd1;
      if (bus.icache_flush) valid_q <= '0;
      else if (install)     valid_q[miss_idx_q] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && install) begin
      tag_q[miss_idx_q]  <= miss_tag_q;
      data_q[miss_idx_q] <= bus.control2cache_data;
    end
  end
endmodule

// File: tb/tb_icache_fill_unit.sv
// Scoreboarded bench for icache_fill_unit: returned lines are queued when driven and popped on the hit.
module tb_icache_fill_unit;
  import icache_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  icache_fill_unit_if bus ();
  icache_fill_unit #(.NUM_LINES(32)) dut (.clock(clock), .reset(reset), .bus(bus));

  logic [63:0] fill_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int exp_hits = 0;
  int exp_miss = 0;
  int loads;

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in();
    bus.proc2Icache_req              = 1'b0;
    bus.proc2Icache_addr             = '0;
    bus.icache_flush                 = 1'b0;
    bus.control2cache_response       = 4'd0;
    bus.control2cache_response_which = DCACHE;
    bus.control2cache_data           = 64'd0;
    bus.control2cache_tag            = 4'd0;
    bus.control2cache_tag_which      = DCACHE;
  endtask

  task automatic chk_hit(string name);
    logic [63:0] d;
    #1;
    if (fill_q.size() == 0) begin
      check({name, "_sb_empty"}, 64'(fill_q.size()), 64'd1);
    end else begin
      d = fill_q.pop_front();
      check({name, "_vld"}, 64'(bus.Icache_valid_out), 64'd1);
      check({name, "_dat"}, bus.Icache_data_out, d);
    end
    exp_hits++;
  endtask

  task automatic chk_miss(string name, logic [XLEN-1:0] a);
    #1;
    check({name, "_vld"}, 64'(bus.Icache_valid_out), 64'd0);
    check({name, "_dat"}, bus.Icache_data_out, 64'd0);
    check({name, "_cmd"}, 64'(bus.icache_command), 64'(BUS_LOAD));
    check({name, "_addr"}, 64'(bus.icache_addr), 64'({a[XLEN-1:3], 3'b000}));
  endtask

  task automatic do_fill(string name, logic [XLEN-1:0] a, logic [3:0] gtag, logic [63:0] d);
    bus.proc2Icache_req              = 1'b1;
    bus.proc2Icache_addr             = a;
    bus.control2cache_response       = gtag;
    bus.control2cache_response_which = ICACHE;
    chk_miss({name, "_miss"}, a);
    exp_miss++;
    tick();
    bus.control2cache_response  = 4'd0;
    bus.proc2Icache_req         = 1'b0;
    bus.control2cache_tag       = gtag;
    bus.control2cache_tag_which = ICACHE;
    bus.control2cache_data      = d;
    fill_q.push_back(d);
    tick();
    bus.control2cache_tag = 4'd0;
    bus.proc2Icache_req   = 1'b1;
    chk_hit({name, "_hit"});
    tick();
    bus.proc2Icache_req = 1'b0;
  endtask

  task automatic chk_reset_state(string name);
    #1;
    check({name, "_vld"}, 64'(bus.Icache_valid_out), 64'd0);
    check({name, "_dat"}, bus.Icache_data_out, 64'd0);
    check({name, "_cmd"}, 64'(bus.icache_command), 64'(BUS_NONE));
    check({name, "_addr"}, 64'(bus.icache_addr), 64'd0);
    check({name, "_hitcnt"}, 64'(bus.icache_hit_count), 64'd0);
    check({name, "_misscnt"}, 64'(bus.icache_miss_count), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    idle_in();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk_reset_state("reset");

    // Cold miss: grant tag 3 with the request, data four cycles later.
    bus.proc2Icache_req              = 1'b1;
    bus.proc2Icache_addr             = 32'h100;
    bus.control2cache_response       = 4'd3;
    bus.control2cache_response_which = ICACHE;
    chk_miss("cold_req", 32'h100);
    exp_miss++;
    tick();
    bus.control2cache_response = 4'd0;
    #1;
    check("cold_wait_cmd", 64'(bus.icache_command), 64'(BUS_NONE));
    check("cold_misscnt", 64'(bus.icache_miss_count), 64'(exp_miss));
    tick();
    tick();
    tick();
    bus.control2cache_tag       = 4'd3;
    bus.control2cache_tag_which = ICACHE;
    bus.control2cache_data      = 64'hDEADBEEF_CAFEF00D;
    #1;
    check("cold_nobypass", 64'(bus.Icache_valid_out), 64'd0);
    tick();
    bus.control2cache_tag = 4'd0;

    // Hit stream: five consecutive hits, no bus traffic.
    for (int i = 0; i < 5; i++) begin
      fill_q.push_back(64'hDEADBEEF_CAFEF00D);
      chk_hit("stream");
      check("stream_cmd", 64'(bus.icache_command), 64'(BUS_NONE));
      tick();
    end
    check("stream_hitcnt", 64'(bus.icache_hit_count), 64'd5);

    // Grant stall: three cycles without grant, then tag 7.
    bus.proc2Icache_addr = 32'h20C;
    loads = 0;
    for (int i = 0; i < 3; i++) begin
      chk_miss("stall_req", 32'h20C);
      if (bus.icache_command == BUS_LOAD) loads++;
      tick();
    end
    bus.control2cache_response       = 4'd7;
    bus.control2cache_response_which = ICACHE;
    #1;
    if (bus.icache_command == BUS_LOAD) loads++;
    exp_miss++;
    tick();
    bus.control2cache_response = 4'd0;
    check("stall_loads", 64'(loads), 64'd4);
    check("stall_misscnt", 64'(bus.icache_miss_count), 64'(exp_miss));
    bus.proc2Icache_req         = 1'b0;
    bus.control2cache_tag       = 4'd7;
    bus.control2cache_tag_which = ICACHE;
    bus.control2cache_data      = 64'h0123_4567_89AB_CDEF;
    fill_q.push_back(64'h0123_4567_89AB_CDEF);
    tick();
    bus.control2cache_tag = 4'd0;
    bus.proc2Icache_req   = 1'b1;
    bus.proc2Icache_addr  = 32'h208;
    chk_hit("stall_hit");
    tick();

    // Foreign traffic in WAIT_DATA on tag 5.
    bus.proc2Icache_addr             = 32'h210;
    bus.control2cache_response       = 4'd5;
    bus.control2cache_response_which = ICACHE;
    exp_miss++;
    tick();
    bus.control2cache_response  = 4'd0;
    bus.proc2Icache_req         = 1'b0;
    bus.control2cache_tag       = 4'd5;
    bus.control2cache_tag_which = DCACHE;
    bus.control2cache_data      = 64'hBAD0_BAD0_BAD0_BAD0;
    tick();
    bus.control2cache_tag       = 4'd2;
    bus.control2cache_tag_which = ICACHE;
    tick();
    bus.control2cache_tag = 4'd0;
    bus.proc2Icache_req   = 1'b1;
    #1;
    check("foreign_noinstall", 64'(bus.Icache_valid_out), 64'd0);
    check("foreign_waitcmd", 64'(bus.icache_command), 64'(BUS_NONE));
    bus.control2cache_tag       = 4'd5;
    bus.control2cache_tag_which = ICACHE;
    bus.control2cache_data      = 64'h5555_AAAA_1234_5678;
    fill_q.push_back(64'h5555_AAAA_1234_5678);
    tick();
    bus.control2cache_tag = 4'd0;
    chk_hit("foreign_hit");
    check("foreign_misscnt", 64'(bus.icache_miss_count), 64'(exp_miss));
    tick();

    // Flush mid-miss, then flush coincident with the return.
    bus.proc2Icache_addr             = 32'h218;
    bus.control2cache_response       = 4'd6;
    bus.control2cache_response_which = ICACHE;
    exp_miss++;
    tick();
    bus.control2cache_response = 4'd0;
    bus.proc2Icache_req        = 1'b0;
    bus.icache_flush           = 1'b1;
    tick();
    bus.icache_flush            = 1'b0;
    bus.control2cache_tag       = 4'd6;
    bus.control2cache_tag_which = ICACHE;
    bus.control2cache_data      = 64'h6666_6666_6666_6666;
    tick();
    bus.control2cache_tag = 4'd0;
    bus.proc2Icache_req   = 1'b1;
    chk_miss("flush_refetch", 32'h218);
    bus.proc2Icache_addr = 32'h208;
    chk_miss("flush_cleared", 32'h208);
    bus.proc2Icache_addr             = 32'h218;
    bus.control2cache_response       = 4'd8;
    bus.control2cache_response_which = ICACHE;
    exp_miss++;
    tick();
    bus.control2cache_response  = 4'd0;
    bus.proc2Icache_req         = 1'b0;
    bus.control2cache_tag       = 4'd8;
    bus.control2cache_tag_which = ICACHE;
    bus.icache_flush            = 1'b1;
    tick();
    bus.control2cache_tag = 4'd0;
    bus.icache_flush      = 1'b0;
    bus.proc2Icache_req   = 1'b1;
    chk_miss("flush_sametick", 32'h218);
    bus.proc2Icache_req = 1'b0;
    tick();

    // Conflict: 0x100 and 0x200 share index 0.
    do_fill("conf_a", 32'h100, 4'd1, 64'hA1A1_A1A1_0000_0100);
    do_fill("conf_b", 32'h200, 4'd2, 64'hB2B2_B2B2_0000_0200);
    bus.proc2Icache_req  = 1'b1;
    bus.proc2Icache_addr = 32'h100;
    chk_miss("conf_evict", 32'h100);
    check("conf_misscnt", 64'(bus.icache_miss_count), 64'(exp_miss));
    check("conf_hitcnt", 64'(bus.icache_hit_count), 64'(exp_hits));
    bus.proc2Icache_req = 1'b0;
    tick();

    // Reset during WAIT_DATA; the late return must be ignored.
    bus.proc2Icache_req              = 1'b1;
    bus.proc2Icache_addr             = 32'h100;
    bus.control2cache_response       = 4'd4;
    bus.control2cache_response_which = ICACHE;
    tick();
    bus.control2cache_response = 4'd0;
    bus.proc2Icache_req        = 1'b0;
    reset                      = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset_state("midreset");
    bus.control2cache_tag       = 4'd4;
    bus.control2cache_tag_which = ICACHE;
    bus.control2cache_data      = 64'h4444_4444_4444_4444;
    tick();
    bus.control2cache_tag = 4'd0;
    bus.proc2Icache_req   = 1'b1;
    chk_miss("midreset_noinstall", 32'h100);
    bus.proc2Icache_req = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
